// File: rtl/fwd_hazard_pkg.sv
// Shared encodings for fwd_hazard_ctrl: forwarding selects, FSM states and the
// layout of an in-flight producer tag {valid, we, reg, is_load}.
package fwd_hazard_pkg;

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_MEMWB = 2'd1;
  localparam logic [1:0] SEL_EXMEM = 2'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_HOLD = 2'd2
  } state_t;

  // Bit positions inside a tag; valid and we sit above the RADDR_W-wide reg field.
  localparam int TAG_LOAD_BIT  = 0;
  localparam int TAG_REG_LSB   = 1;
  localparam int TAG_WE_OFS    = 1;
  localparam int TAG_VALID_OFS = 2;
  localparam int TAG_EXTRA     = 3;

  function automatic int tag_width(input int raddr_w);
    return raddr_w + TAG_EXTRA;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Per-source producer compare and EX operand select for fwd_hazard_ctrl.
// Behaviour depends on FWD_HAZARD_BYPASS_EN (forwarding) vs. stall-only default.
module fwd_src_sel
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic                         id_valid,
  input  logic                         src_used,
  input  logic [RADDR_W-1:0]           src_reg,
  input  logic [RADDR_W+TAG_EXTRA-1:0] ex_tag,
  input  logic [RADDR_W+TAG_EXTRA-1:0] mem_tag,
  input  logic [RADDR_W+TAG_EXTRA-1:0] wb_tag,
  input  logic [1:0]                   cur_sel,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [DATA_W-1:0]            exmem_data,
  input  logic [DATA_W-1:0]            memwb_data,
  output logic                         stall_req,
  output logic [1:0]                   next_sel,
  output logic [DATA_W-1:0]            op_data
);

  localparam int VALID_BIT = RADDR_W + TAG_VALID_OFS;
  localparam int WE_BIT    = RADDR_W + TAG_WE_OFS;

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_bits;

  function automatic logic producer_hit(input logic [RADDR_W+TAG_EXTRA-1:0] tag,
                                        input logic [RADDR_W-1:0] rd);
    return tag[VALID_BIT] && tag[WE_BIT] && (tag[TAG_REG_LSB +: RADDR_W] == rd);
  endfunction

  assign hit_ex  = id_valid && src_used && producer_hit(ex_tag, src_reg);
  assign hit_mem = id_valid && src_used && producer_hit(mem_tag, src_reg);
  assign hit_wb  = id_valid && src_used && producer_hit(wb_tag, src_reg);

`ifdef FWD_HAZARD_BYPASS_EN
  // Only a load still in EX cannot be forwarded in time; everything else bypasses.
  assign stall_req   = hit_ex && ex_tag[TAG_LOAD_BIT];
  assign next_sel    = hit_ex ? SEL_EXMEM : (hit_mem ? SEL_MEMWB : SEL_RF);
  assign unused_bits = ^{hit_wb, mem_tag[TAG_LOAD_BIT], wb_tag[TAG_LOAD_BIT]};
`else
  assign stall_req   = hit_ex || hit_mem || hit_wb;
  assign next_sel    = SEL_RF;
  assign unused_bits = ^{ex_tag[TAG_LOAD_BIT], mem_tag[TAG_LOAD_BIT], wb_tag[TAG_LOAD_BIT]};
`endif

  always_comb begin
    case (cur_sel)
      SEL_EXMEM: op_data = exmem_data;
      SEL_MEMWB: op_data = memwb_data;
      default:   op_data = rf_data;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller for a 5-stage pipeline: tracks producers in
// EX/MEM/WB and drives operand selects and stalls. Define FWD_HAZARD_BYPASS_EN for forwarding.
module fwd_hazard_ctrl
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int NUM_SRC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*RADDR_W-1:0]  id_src_reg,
  input  logic                        id_we,
  input  logic                        id_is_load,
  input  logic [RADDR_W-1:0]          id_dst_reg,
  input  logic                        mem_busy,
  input  logic                        flush,
  input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_data,
  input  logic [DATA_W-1:0]           exmem_data,
  input  logic [DATA_W-1:0]           memwb_data,
  output logic [NUM_SRC*DATA_W-1:0]   ex_op_data,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic                        stall_id,
  output logic                        bubble_ex,
  output logic                        hold_all
);

  localparam int TAG_W = tag_width(RADDR_W);

  logic [TAG_W-1:0]     id_tag;
  logic [TAG_W-1:0]     ex_tag;
  logic [TAG_W-1:0]     mem_tag;
  logic [TAG_W-1:0]     wb_tag;
  logic [NUM_SRC-1:0]   stall_req;
  logic [2*NUM_SRC-1:0] sel_d;
  logic                 hazard;
  logic                 eff_flush;
  logic                 squash;
  logic                 pend_flush;
  state_t               state;
  state_t               state_next;

  assign id_tag = {id_valid, id_we, id_dst_reg, id_is_load};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_sel #(
      .DATA_W (DATA_W),
      .RADDR_W(RADDR_W)
    ) u_sel (
      .id_valid  (id_valid),
      .src_used  (id_src_used[g]),
      .src_reg   (id_src_reg[g*RADDR_W +: RADDR_W]),
      .ex_tag    (ex_tag),
      .mem_tag   (mem_tag),
      .wb_tag    (wb_tag),
      .cur_sel   (fwd_sel[2*g +: 2]),
      .rf_data   (ex_rf_data[g*DATA_W +: DATA_W]),
      .exmem_data(exmem_data),
      .memwb_data(memwb_data),
      .stall_req (stall_req[g]),
      .next_sel  (sel_d[2*g +: 2]),
      .op_data   (ex_op_data[g*DATA_W +: DATA_W])
    );
  end

  // Outputs must act in the same cycle the hazard is seen, so they are decoded
  // from current inputs; the state records a hold so a latched flush lands on exit.
  always_comb begin
    hazard     = |stall_req;
    eff_flush  = flush | (pend_flush & (state == MEM_HOLD));
    hold_all   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    state_next = RUN;
    if (!rst) begin
      if (mem_busy) begin
        hold_all   = 1'b1;
        stall_id   = 1'b1;
        state_next = MEM_HOLD;
      end else if (hazard && !eff_flush) begin
        stall_id   = 1'b1;
        bubble_ex  = 1'b1;
        state_next = LU_STALL;
      end
    end
  end

  assign squash = bubble_ex | eff_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ex_tag     <= '0;
      mem_tag    <= '0;
      wb_tag     <= '0;
      fwd_sel    <= '0;
      pend_flush <= 1'b0;
    end else begin
      state <= state_next;
      if (hold_all) begin
        pend_flush <= pend_flush | flush;
      end else begin
        pend_flush <= 1'b0;
        ex_tag     <= squash ? '0 : id_tag;
        mem_tag    <= ex_tag;
        wb_tag     <= mem_tag;
        fwd_sel    <= squash ? '0 : sel_d;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: a producer-list model checked every
// cycle plus directed dependency scenarios with literal expectations.
module tb_fwd_hazard_ctrl;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int NUM_SRC = 2;

`ifdef FWD_HAZARD_BYPASS_EN
  localparam int          A_STALLS = 0, B_STALLS = 0, C_STALLS = 1, D_STALLS = 1;
  localparam logic [1:0]  A_SEL = 2'd2, B_SEL = 2'd1, C_SEL = 2'd1;
  localparam logic [15:0] A_OP = 16'h1234, B_OP = 16'hBEEF, C_OP = 16'hBEEF;
`else
  localparam int          A_STALLS = 3, B_STALLS = 2, C_STALLS = 3, D_STALLS = 3;
  localparam logic [1:0]  A_SEL = 2'd0, B_SEL = 2'd0, C_SEL = 2'd0;
  localparam logic [15:0] A_OP = 16'h5050, B_OP = 16'h5151, C_OP = 16'h5050;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       id_valid;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [NUM_SRC*RADDR_W-1:0] id_src_reg;
  logic                       id_we;
  logic                       id_is_load;
  logic [RADDR_W-1:0]         id_dst_reg;
  logic                       mem_busy;
  logic                       flush;
  logic [NUM_SRC*DATA_W-1:0]  ex_rf_data;
  logic [DATA_W-1:0]          exmem_data;
  logic [DATA_W-1:0]          memwb_data;
  logic [NUM_SRC*DATA_W-1:0]  ex_op_data;
  logic [2*NUM_SRC-1:0]       fwd_sel;
  logic                       stall_id;
  logic                       bubble_ex;
  logic                       hold_all;

  int n_checks = 0;
  int n_pass   = 0;
  logic check_en;
  int stalls, bubbles;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_used(id_src_used),
    .id_src_reg(id_src_reg), .id_we(id_we), .id_is_load(id_is_load),
    .id_dst_reg(id_dst_reg), .mem_busy(mem_busy), .flush(flush),
    .ex_rf_data(ex_rf_data), .exmem_data(exmem_data), .memwb_data(memwb_data),
    .ex_op_data(ex_op_data), .fwd_sel(fwd_sel), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .hold_all(hold_all)
  );

  // Model: list of producers by stage (0 = EX, 1 = MEM, 2 = WB) and the
  // operand source chosen for whatever instruction sits in EX.
  logic [2:0]         t_valid, t_we, t_load;
  logic [RADDR_W-1:0] t_reg [3];
  logic [1:0]         m_sel [NUM_SRC];
  logic               m_pend;
  logic               m_squash;

  function automatic logic reads_from(int src, int stage);
    return id_valid && id_src_used[src] && t_valid[stage] && t_we[stage] &&
           (id_src_reg[src*RADDR_W +: RADDR_W] == t_reg[stage]);
  endfunction

  function automatic logic must_stall();
    logic h;
    h = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef FWD_HAZARD_BYPASS_EN
      if (reads_from(i, 0) && t_load[0]) h = 1'b1;
`else
      for (int s = 0; s < 3; s++) if (reads_from(i, s)) h = 1'b1;
`endif
    end
    return h;
  endfunction

  function automatic logic [1:0] want_sel(int i);
`ifdef FWD_HAZARD_BYPASS_EN
    if (reads_from(i, 0)) return 2'd2;
    if (reads_from(i, 1)) return 2'd1;
`endif
    return 2'd0 + 2'(i * 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_valid <= '0; t_we <= '0; t_load <= '0; m_pend <= 1'b0;
      for (int i = 0; i < 3; i++) t_reg[i] <= '0;
      for (int i = 0; i < NUM_SRC; i++) m_sel[i] <= 2'd0;
    end else if (mem_busy) begin
      m_pend <= m_pend | flush;
    end else begin
      m_squash = flush || m_pend || must_stall();
      t_valid  <= {t_valid[1:0], m_squash ? 1'b0 : id_valid};
      t_we     <= {t_we[1:0], id_we};
      t_load   <= {t_load[1:0], id_is_load};
      t_reg[2] <= t_reg[1];
      t_reg[1] <= t_reg[0];
      t_reg[0] <= id_dst_reg;
      for (int i = 0; i < NUM_SRC; i++) m_sel[i] <= m_squash ? 2'd0 : want_sel(i);
      m_pend   <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  logic                      e_hold, e_hz;
  logic [2*NUM_SRC-1:0]      e_sel;
  logic [NUM_SRC*DATA_W-1:0] e_op;

  always @(negedge clk) begin
    if (check_en) begin
      e_hold = !rst && mem_busy;
      e_hz   = !rst && !mem_busy && !(flush || m_pend) && must_stall();
      for (int i = 0; i < NUM_SRC; i++) begin
        e_sel[2*i +: 2] = m_sel[i];
        case (m_sel[i])
          2'd2:    e_op[i*DATA_W +: DATA_W] = exmem_data;
          2'd1:    e_op[i*DATA_W +: DATA_W] = memwb_data;
          default: e_op[i*DATA_W +: DATA_W] = ex_rf_data[i*DATA_W +: DATA_W];
        endcase
      end
      checkOutput("cyc_hold_all", hold_all, e_hold);
      checkOutput("cyc_stall_id", stall_id, e_hold || e_hz);
      checkOutput("cyc_bubble_ex", bubble_ex, e_hz);
      checkOutput("cyc_fwd_sel", fwd_sel, e_sel);
      checkOutput("cyc_ex_op_data", ex_op_data, e_op);
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] used, input logic [2:0] r0,
                               input logic [2:0] r1, input logic we, input logic ld,
                               input logic [2:0] dst, input logic busy, input logic fl);
    id_valid = v; id_src_used = used; id_src_reg = {r1, r0};
    id_we = we; id_is_load = ld; id_dst_reg = dst; mem_busy = busy; flush = fl;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
    end
  endtask

  task automatic writer(input logic [2:0] dst, input logic ld);
    applyStimulus(1, 2'b00, 0, 0, 1, ld, dst, 0, 0);
    nextCycle();
  endtask

  // Holds a reader in ID until the controller lets it go, counting stall cycles.
  task automatic readUntilFree(input logic [1:0] used, input logic [2:0] r0, input logic [2:0] r1,
                               output int n_st, output int n_bu);
    n_st = 0;
    n_bu = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, used, r0, r1, 0, 0, 0, 0, 0);
      if (!stall_id) begin
        nextCycle();
        return;
      end
      n_st++;
      if (bubble_ex) n_bu++;
      nextCycle();
    end
    checkOutput("stall_bound_expired", 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    check_en = 1'b0;
    ex_rf_data = {16'h5151, 16'h5050};
    exmem_data = 16'h1234;
    memwb_data = 16'hBEEF;
    id_valid = 0; id_src_used = 0; id_src_reg = 0; id_we = 0;
    id_is_load = 0; id_dst_reg = 0; mem_busy = 1'b1; flush = 0;
    #2;
    checkOutput("reset_stall_id", stall_id, 0);
    checkOutput("reset_bubble_ex", bubble_ex, 0);
    checkOutput("reset_hold_all", hold_all, 0);
    checkOutput("reset_fwd_sel", fwd_sel, 0);
    checkOutput("reset_ex_op_data", ex_op_data, 32'h5151_5050);
    mem_busy = 1'b0;
    #1 rst = 1'b0;
    check_en = 1'b1;
    nextCycle();
    idleCycles(2);

    // ALU r3 then reader of r3 on source 0
    writer(3'd3, 1'b0);
    readUntilFree(2'b01, 3'd3, 3'd0, stalls, bubbles);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_dep_stalls", stalls, A_STALLS);
    checkOutput("alu_dep_sel0", fwd_sel[1:0], A_SEL);
    checkOutput("alu_dep_op0", ex_op_data[15:0], A_OP);
    nextCycle();
    idleCycles(4);

    // ALU r2, unrelated instruction, reader of r2 on source 1
    writer(3'd2, 1'b0);
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    readUntilFree(2'b10, 3'd0, 3'd2, stalls, bubbles);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("memwb_dep_stalls", stalls, B_STALLS);
    checkOutput("memwb_dep_sel1", fwd_sel[3:2], B_SEL);
    checkOutput("memwb_dep_op1", ex_op_data[31:16], B_OP);
    nextCycle();
    idleCycles(4);

    // load r4 then reader of r4
    writer(3'd4, 1'b1);
    readUntilFree(2'b01, 3'd4, 3'd0, stalls, bubbles);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load_use_stalls", stalls, C_STALLS);
    checkOutput("load_use_bubbles", bubbles, C_STALLS);
    checkOutput("load_use_sel0", fwd_sel[1:0], C_SEL);
    checkOutput("load_use_op0", ex_op_data[15:0], C_OP);
    nextCycle();
    idleCycles(4);

    // load-use hidden behind three busy memory cycles
    writer(3'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 2'b01, 3'd4, 3'd0, 0, 0, 0, 1, 0);
      checkOutput("busy_hold_all", hold_all, 1);
      checkOutput("busy_stall_id", stall_id, 1);
      checkOutput("busy_bubble_ex", bubble_ex, 0);
      nextCycle();
    end
    readUntilFree(2'b01, 3'd4, 3'd0, stalls, bubbles);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_busy_stalls", stalls, D_STALLS);
    checkOutput("post_busy_sel0", fwd_sel[1:0], C_SEL);
    nextCycle();
    idleCycles(4);

    // flush beats load-use
    writer(3'd4, 1'b1);
    applyStimulus(1, 2'b01, 3'd4, 3'd0, 0, 0, 0, 0, 1);
    checkOutput("flush_lu_stall_id", stall_id, 0);
    checkOutput("flush_lu_bubble_ex", bubble_ex, 0);
    nextCycle();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_lu_sel", fwd_sel, 0);
    nextCycle();
    idleCycles(4);

    // flush seen during a memory hold squashes the writer of r6 on release
    applyStimulus(1, 2'b00, 0, 0, 1, 0, 3'd6, 1, 1);
    checkOutput("flush_hold_hold_all", hold_all, 1);
    nextCycle();
    applyStimulus(1, 2'b00, 0, 0, 1, 0, 3'd6, 0, 0);
    checkOutput("flush_exit_stall_id", stall_id, 0);
    nextCycle();
    readUntilFree(2'b01, 3'd6, 3'd0, stalls, bubbles);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flushed_writer_stalls", stalls, 0);
    checkOutput("flushed_writer_sel", fwd_sel, 0);
    nextCycle();
    idleCycles(4);

    // reset in the middle of a load-use stall
    writer(3'd4, 1'b1);
    applyStimulus(1, 2'b01, 3'd4, 3'd0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_stall_id", stall_id, 1);
    checkOutput("pre_rst_bubble_ex", bubble_ex, 1);
    #1 rst = 1'b1;
    mem_busy = 1'b1;
    #1;
    checkOutput("rst_stall_id", stall_id, 0);
    checkOutput("rst_bubble_ex", bubble_ex, 0);
    checkOutput("rst_hold_all", hold_all, 0);
    checkOutput("rst_fwd_sel", fwd_sel, 0);
    #2 rst = 1'b0;
    mem_busy = 1'b0;
    nextCycle();
    readUntilFree(2'b01, 3'd4, 3'd0, stalls, bubbles);
    checkOutput("post_rst_stalls", stalls, 0);
    idleCycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
